// File: rtl/gate_probe.sv
// gate_probe: walks a 2-input gate through rows 00..11, samples its
// response after SETTLE cycles per row and reports the 4-bit truth-table code.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   start  level-sampled run request (ignored while busy)
//   s_in   response bit from the gate under test
//   x, y   gate inputs a, b ({x,y} is the current row index)
//   code   truth table, code[m] = response for row m
//   valid  code/match complete; holds until the next accepted start
//   match  code == EXPECT, meaningful while valid
//   busy   run in progress
module gate_probe #(
  parameter int unsigned SETTLE = 1,
  parameter logic [3:0]  EXPECT = 4'b0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic [3:0] code,
  output logic       valid,
  output logic       match,
  output logic       busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  logic [0:0] r_state;
  logic [1:0] r_m;
  logic [3:0] r_cnt;
  logic [3:0] r_code;
  logic       r_valid;
  logic       r_match;

  logic       w_run;
  logic       w_sample;
  logic       w_last_row;
  logic [3:0] w_code_nxt;

  assign w_run      = (r_state == S_RUN);
  assign w_sample   = w_run && !(r_cnt < LAST_CNT);
  assign w_last_row = (r_m == 2'd3);

  // code with the current row's bit replaced by the live response;
  // used both for the register update and the final comparison
  always_comb begin
    w_code_nxt      = r_code;
    w_code_nxt[r_m] = s_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_m     <= 2'd0;
      r_cnt   <= 4'd0;
      r_code  <= 4'd0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_m     <= 2'd0;
            r_cnt   <= 4'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
          end
        end
        S_RUN: begin
          if (!w_sample) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_code <= w_code_nxt;
            r_cnt  <= 4'd0;
            if (!w_last_row) begin
              r_m <= r_m + 2'd1;
            end else begin
              // row index returns to 00, which also parks x/y at 0
              r_m     <= 2'd0;
              r_state <= S_IDLE;
              r_valid <= 1'b1;
              r_match <= (w_code_nxt == EXPECT);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // the row index is the gate stimulus directly: {x,y} == m
  assign x     = r_m[1];
  assign y     = r_m[0];
  assign code  = r_code;
  assign valid = r_valid;
  assign match = r_match;
  assign busy  = w_run;

endmodule

// File: tb/tb_gate_probe.sv
// tb_gate_probe: scoreboard bench for gate_probe with a SETTLE=1
// combinational device and a SETTLE=3 device behind two register stages.
module tb_gate_probe;

  localparam logic [3:0] EXP = 4'b0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [3:0] func1 = 4'b0010;
  logic [3:0] func3 = 4'b0010;

  logic       x1, y1, valid1, match1, busy1, s1;
  logic [3:0] code1;
  logic       x3, y3, valid3, match3, busy3, s3;
  logic [3:0] code3;
  logic       d3a, d3b;

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0] code;
    logic       match;
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // device behaviour: truth table lookup, row m = {a,b}
  assign s1 = func1[{x1, y1}];

  always @(posedge clk) begin
    d3a <= func3[{x3, y3}];
    d3b <= d3a;
  end
  assign s3 = d3b;

  gate_probe #(.SETTLE(1), .EXPECT(EXP)) u1 (
    .clk(clk), .reset(reset), .start(start1), .s_in(s1),
    .x(x1), .y(y1), .code(code1), .valid(valid1),
    .match(match1), .busy(busy1)
  );

  gate_probe #(.SETTLE(3), .EXPECT(EXP)) u3 (
    .clk(clk), .reset(reset), .start(start3), .s_in(s3),
    .x(x3), .y(y3), .code(code3), .valid(valid3),
    .match(match3), .busy(busy3)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " u1"}, {x1, y1, code1, valid1, match1, busy1}, 0);
    chk({nm, " u3"}, {x3, y3, code3, valid3, match3, busy3}, 0);
  endtask

  // monitors: pop expected result whenever valid rises
  logic pv1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valid1 && !pv1) begin
      if (q1.size() == 0) begin
        chk("u1 unexpected valid", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("u1 code", code1, e.code);
        chk("u1 match", match1, e.match);
        chk("u1 latency", cyc, e.due);
        chk("u1 idle at done", {busy1, x1, y1}, 0);
      end
    end
    pv1 <= valid1;
  end

  logic pv3 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valid3 && !pv3) begin
      if (q3.size() == 0) begin
        chk("u3 unexpected valid", 1, 0);
      end else begin
        e = q3.pop_front();
        chk("u3 code", code3, e.code);
        chk("u3 match", match3, e.match);
        chk("u3 latency", cyc, e.due);
        chk("u3 idle at done", {busy3, x3, y3}, 0);
      end
    end
    pv3 <= valid3;
  end

  function automatic exp_t mk(logic [3:0] f, int due);
    exp_t e;
    e.code  = f;
    e.match = (f == EXP);
    e.due   = due;
    return e;
  endfunction

  // single-pulse run on u1; random start pulses while busy must be ignored
  task automatic run1(logic [3:0] f);
    func1  = f;
    start1 = 1'b1;
    q1.push_back(mk(f, cyc + 1 + 4));
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      chk("u1 row", {x1, y1}, r);
      chk("u1 busy", busy1, 1);
      start1 = 1'($urandom % 2);
      @(negedge clk);
    end
    start1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic run3(logic [3:0] f);
    func3  = f;
    start3 = 1'b1;
    q3.push_back(mk(f, cyc + 1 + 12));
    @(negedge clk);
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("u3 row hold", {x3, y3}, i / 3);
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int vhigh;
    repeat (2) @(negedge clk);
    chk_zero("reset state");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("idle no start");
    end

    run1(4'b0010);
    run1(4'b1000);
    run1(4'b1110);
    run1(4'b0000);
    for (int i = 0; i < 10; i++) run1(4'($urandom));

    // async reset between edges while results are held
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // held start: accepts every 5 cycles, valid high one cycle each time
    func1  = 4'b0010;
    start1 = 1'b1;
    k = cyc;
    for (int r = 0; r < 3; r++) q1.push_back(mk(4'b0010, k + 5 + 5 * r));
    vhigh = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (valid1) vhigh++;
      if (i == 6 || i == 11) chk("held restart row", {busy1, x1, y1}, 3'b100);
      if (i == 15) start1 = 1'b0;
    end
    chk("held valid cycles", vhigh, 3);
    @(negedge clk);
    chk("held stops", busy1, 0);

    // reset mid-run while row 10 is driven
    func1  = 4'b0010;
    start1 = 1'b1;
    q1.push_back(mk(4'b0010, cyc + 5));
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("row before reset", {x1, y1}, 2'b10);
    reset = 1'b1;
    void'(q1.pop_back());
    #1 chk_zero("mid-run reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run1(4'b0010);

    // SETTLE=3 with a two-stage delayed device
    run3(4'b0010);
    run3(4'b1000);
    for (int i = 0; i < 3; i++) run3(4'($urandom));

    repeat (3) @(negedge clk);
    chk("u1 queue drained", q1.size(), 0);
    chk("u3 queue drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
